// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns a single-cycle CPU data-memory access into a
// request/ready bus transaction. The pipeline is stalled while the access is
// in flight, and misaligned accesses and bus timeouts are reported.
//
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   cpuAddress, cpuWriteData     byte address and store data from the memory stage
//   cpuShouldWriteMemory/Read    store / load request (write wins if both are set)
//   cpuReadData                  load result, valid in DONE, held between loads
//   cpuStall                     combinational pipeline freeze
//   cpuError                     one-cycle pulse in DONE for a failed access
//   errorCount                   saturating count of failed accesses
//   busRequest/Write/Address/WriteData   bus transaction outputs (registered)
//   busReady, busReadData        slave completion and read data
module data_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpuAddress,
    input  logic [31:0] cpuWriteData,
    input  logic        cpuShouldWriteMemory,
    input  logic        cpuShouldReadMemory,
    output logic [31:0] cpuReadData,
    output logic        cpuStall,
    output logic        cpuError,
    output logic [7:0]  errorCount,
    output logic        busRequest,
    output logic        busWrite,
    output logic [31:0] busAddress,
    output logic [31:0] busWriteData,
    input  logic        busReady,
    input  logic [31:0] busReadData
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               request_nxt;
    logic               write_nxt;
    logic [DATA_W-1:0]  address_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic [DATA_W-1:0]  rdata_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [CNT_W-1:0]   errors_nxt;
    logic               error_flag, error_nxt;
    logic               stall_c;
    logic               access;
    logic               aligned;

    assign access  = cpuShouldWriteMemory | cpuShouldReadMemory;
    assign aligned = (cpuAddress[1:0] == 2'b00);

    // Reset gates the stall so the pipeline is released the moment reset asserts.
    assign cpuStall = stall_c & reset;
    assign cpuError = (state == DONE) & error_flag;

    // State register and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busRequest   <= 1'b0;
            busWrite     <= 1'b0;
            busAddress   <= '0;
            busWriteData <= '0;
            cpuReadData  <= '0;
            count        <= '0;
            errorCount   <= '0;
            error_flag   <= 1'b0;
        end else begin
            state        <= state_nxt;
            busRequest   <= request_nxt;
            busWrite     <= write_nxt;
            busAddress   <= address_nxt;
            busWriteData <= wdata_nxt;
            cpuReadData  <= rdata_nxt;
            count        <= count_nxt;
            errorCount   <= errors_nxt;
            error_flag   <= error_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt   = state;
        request_nxt = busRequest;
        write_nxt   = busWrite;
        address_nxt = busAddress;
        wdata_nxt   = busWriteData;
        rdata_nxt   = cpuReadData;
        count_nxt   = count;
        errors_nxt  = errorCount;
        error_nxt   = error_flag;
        stall_c     = 1'b0;

        case (state)
            IDLE: begin
                stall_c = access;
                if (access) begin
                    if (aligned) begin
                        state_nxt   = REQUEST;
                        request_nxt = 1'b1;
                        write_nxt   = cpuShouldWriteMemory;
                        address_nxt = {cpuAddress[DATA_W-1:2], 2'b00};
                        wdata_nxt   = cpuWriteData;
                        count_nxt   = '0;
                        error_nxt   = 1'b0;
                    end else begin
                        // Misaligned: never reaches the bus, fails straight away.
                        state_nxt = DONE;
                        error_nxt = 1'b1;
                        if (!cpuShouldWriteMemory) begin
                            rdata_nxt = ERROR_DATA;
                        end
                    end
                end
            end

            REQUEST: begin
                stall_c = 1'b1;
                // Ready is checked first so a last-cycle completion is not aborted.
                if (busReady) begin
                    state_nxt   = DONE;
                    request_nxt = 1'b0;
                    error_nxt   = 1'b0;
                    if (!busWrite) begin
                        rdata_nxt = busReadData;
                    end
                end else if (count == CNT_LAST) begin
                    state_nxt   = DONE;
                    request_nxt = 1'b0;
                    error_nxt   = 1'b1;
                    if (!busWrite) begin
                        rdata_nxt = ERROR_DATA;
                    end
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
                if (error_flag && (errorCount != CNT_MAX)) begin
                    errors_nxt = errorCount + CNT_W'(1);
                end
            end

            default: begin
                state_nxt   = IDLE;
                request_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge with TIMEOUT_CYCLES = 4. One table entry
// per clock cycle: inputs driven after the falling edge, outputs checked 1 ns
// later. Saturation and asynchronous reset are covered by hand sequences.
module tb_data_bus_bridge;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam int unsigned NV       = 32;

    logic        clock;
    logic        reset;
    logic [31:0] cpuAddress;
    logic [31:0] cpuWriteData;
    logic        cpuShouldWriteMemory;
    logic        cpuShouldReadMemory;
    logic [31:0] cpuReadData;
    logic        cpuStall;
    logic        cpuError;
    logic [7:0]  errorCount;
    logic        busRequest;
    logic        busWrite;
    logic [31:0] busAddress;
    logic [31:0] busWriteData;
    logic        busReady;
    logic [31:0] busReadData;

    int n_chk;
    int n_err;

    data_bus_bridge #(
        .TIMEOUT_CYCLES(4),
        .ERROR_DATA    (ERR_DATA)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .cpuAddress          (cpuAddress),
        .cpuWriteData        (cpuWriteData),
        .cpuShouldWriteMemory(cpuShouldWriteMemory),
        .cpuShouldReadMemory (cpuShouldReadMemory),
        .cpuReadData         (cpuReadData),
        .cpuStall            (cpuStall),
        .cpuError            (cpuError),
        .errorCount          (errorCount),
        .busRequest          (busRequest),
        .busWrite            (busWrite),
        .busAddress          (busAddress),
        .busWriteData        (busWriteData),
        .busReady            (busReady),
        .busReadData         (busReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] brd;
        logic        e_stall;
        logic        e_req;
        logic        e_bwr;
        logic [31:0] e_baddr;
        logic [31:0] e_bwd;
        logic [31:0] e_rdata;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t v(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rdy, input logic [31:0] brd,
                               input logic st, input logic rq, input logic bw,
                               input logic [31:0] ba, input logic [31:0] bwd,
                               input logic [31:0] crd, input logic er,
                               input logic [7:0] ec);
        vec_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata;
        t.rdy = rdy; t.brd = brd;
        t.e_stall = st; t.e_req = rq; t.e_bwr = bw; t.e_baddr = ba; t.e_bwd = bwd;
        t.e_rdata = crd; t.e_err = er; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rdy, input logic [31:0] brd);
        cpuShouldReadMemory  = rd;
        cpuShouldWriteMemory = wr;
        cpuAddress           = addr;
        cpuWriteData         = wdata;
        busReady             = rdy;
        busReadData          = brd;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'h0);

        // Column order: rd wr addr wdata rdy brd | stall req bwr baddr bwd rdata err cnt
        // Aligned read, ready on the third REQUEST cycle.
        vecs[0]  = v(1,0,32'h100,32'h0,0,32'h0,          1,0,0,32'h0,32'h0,32'h0,0,8'd0);
        vecs[1]  = v(1,0,32'h100,32'h0,0,32'h0,          1,1,0,32'h100,32'h0,32'h0,0,8'd0);
        vecs[2]  = v(1,0,32'h100,32'h0,0,32'h0,          1,1,0,32'h100,32'h0,32'h0,0,8'd0);
        vecs[3]  = v(1,0,32'h100,32'h0,1,32'h1234_5678,  1,1,0,32'h100,32'h0,32'h0,0,8'd0);
        vecs[4]  = v(1,0,32'h100,32'h0,0,32'h0,          0,0,0,32'h0,32'h0,32'h1234_5678,0,8'd0);
        vecs[5]  = v(0,0,32'h0,32'h0,0,32'h0,            0,0,0,32'h0,32'h0,32'h1234_5678,0,8'd0);
        // Aligned write, ready on the first REQUEST cycle; read data must be ignored.
        vecs[6]  = v(0,1,32'h204,32'hA5A5_A5A5,0,32'h0,  1,0,0,32'h0,32'h0,32'h1234_5678,0,8'd0);
        vecs[7]  = v(0,1,32'h204,32'hA5A5_A5A5,1,32'hFFFF_FFFF, 1,1,1,32'h204,32'hA5A5_A5A5,32'h1234_5678,0,8'd0);
        vecs[8]  = v(0,1,32'h204,32'hA5A5_A5A5,0,32'h0,  0,0,0,32'h0,32'h0,32'h1234_5678,0,8'd0);
        vecs[9]  = v(0,0,32'h0,32'h0,0,32'h0,            0,0,0,32'h0,32'h0,32'h1234_5678,0,8'd0);
        // Misaligned load.
        vecs[10] = v(1,0,32'h102,32'h0,0,32'h0,          1,0,0,32'h0,32'h0,32'h1234_5678,0,8'd0);
        vecs[11] = v(1,0,32'h102,32'h0,0,32'h0,          0,0,0,32'h0,32'h0,ERR_DATA,1,8'd0);
        vecs[12] = v(0,0,32'h0,32'h0,0,32'h0,            0,0,0,32'h0,32'h0,ERR_DATA,0,8'd1);
        // Read completing on the 4th (last) REQUEST cycle.
        vecs[13] = v(1,0,32'h300,32'h0,0,32'h0,          1,0,0,32'h0,32'h0,ERR_DATA,0,8'd1);
        vecs[14] = v(1,0,32'h300,32'h0,0,32'h0,          1,1,0,32'h300,32'h0,ERR_DATA,0,8'd1);
        vecs[15] = v(1,0,32'h300,32'h0,0,32'h0,          1,1,0,32'h300,32'h0,ERR_DATA,0,8'd1);
        vecs[16] = v(1,0,32'h300,32'h0,0,32'h0,          1,1,0,32'h300,32'h0,ERR_DATA,0,8'd1);
        vecs[17] = v(1,0,32'h300,32'h0,1,32'hCAFE_F00D,  1,1,0,32'h300,32'h0,ERR_DATA,0,8'd1);
        vecs[18] = v(1,0,32'h300,32'h0,0,32'h0,          0,0,0,32'h0,32'h0,32'hCAFE_F00D,0,8'd1);
        vecs[19] = v(0,0,32'h0,32'h0,0,32'h0,            0,0,0,32'h0,32'h0,32'hCAFE_F00D,0,8'd1);
        // Read that times out after exactly 4 request cycles.
        vecs[20] = v(1,0,32'h304,32'h0,0,32'h0,          1,0,0,32'h0,32'h0,32'hCAFE_F00D,0,8'd1);
        vecs[21] = v(1,0,32'h304,32'h0,0,32'h0,          1,1,0,32'h304,32'h0,32'hCAFE_F00D,0,8'd1);
        vecs[22] = v(1,0,32'h304,32'h0,0,32'h0,          1,1,0,32'h304,32'h0,32'hCAFE_F00D,0,8'd1);
        vecs[23] = v(1,0,32'h304,32'h0,0,32'h0,          1,1,0,32'h304,32'h0,32'hCAFE_F00D,0,8'd1);
        vecs[24] = v(1,0,32'h304,32'h0,0,32'h0,          1,1,0,32'h304,32'h0,32'hCAFE_F00D,0,8'd1);
        vecs[25] = v(1,0,32'h304,32'h0,0,32'h0,          0,0,0,32'h0,32'h0,ERR_DATA,1,8'd1);
        // Stray busReady in IDLE is ignored.
        vecs[26] = v(0,0,32'h0,32'h0,1,32'h1111_1111,    0,0,0,32'h0,32'h0,ERR_DATA,0,8'd2);
        vecs[27] = v(0,0,32'h0,32'h0,0,32'h0,            0,0,0,32'h0,32'h0,ERR_DATA,0,8'd2);
        // Read and write together: issued as a write.
        vecs[28] = v(1,1,32'h40,32'h0BAD_F00D,0,32'h0,   1,0,0,32'h0,32'h0,ERR_DATA,0,8'd2);
        vecs[29] = v(1,1,32'h40,32'h0BAD_F00D,1,32'h2222_2222, 1,1,1,32'h40,32'h0BAD_F00D,ERR_DATA,0,8'd2);
        vecs[30] = v(1,1,32'h40,32'h0BAD_F00D,0,32'h0,   0,0,0,32'h0,32'h0,ERR_DATA,0,8'd2);
        vecs[31] = v(0,0,32'h0,32'h0,0,32'h0,            0,0,0,32'h0,32'h0,ERR_DATA,0,8'd2);

        // Reset state, with a request present to show the stall is gated.
        repeat (2) @(negedge clock);
        #1;
        chk("reset stall",   32'(cpuStall),   32'h0);
        chk("reset req",     32'(busRequest), 32'h0);
        chk("reset rdata",   cpuReadData,     32'h0);
        chk("reset errcnt",  32'(errorCount), 32'h0);
        chk("reset cpuerr",  32'(cpuError),   32'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < int'(NV); i++) begin
            @(negedge clock);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdy, vecs[i].brd);
            #1;
            chk($sformatf("v%0d stall", i),  32'(cpuStall),   32'(vecs[i].e_stall));
            chk($sformatf("v%0d req", i),    32'(busRequest), 32'(vecs[i].e_req));
            chk($sformatf("v%0d rdata", i),  cpuReadData,     vecs[i].e_rdata);
            chk($sformatf("v%0d cpuerr", i), 32'(cpuError),   32'(vecs[i].e_err));
            chk($sformatf("v%0d errcnt", i), 32'(errorCount), 32'(vecs[i].e_cnt));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d bwrite", i), 32'(busWrite), 32'(vecs[i].e_bwr));
                chk($sformatf("v%0d baddr", i),  busAddress,    vecs[i].e_baddr);
                if (vecs[i].e_bwr)
                    chk($sformatf("v%0d bwdata", i), busWriteData, vecs[i].e_bwd);
            end
        end

        // 260 back-to-back misaligned loads: count runs 2 -> 255 and holds.
        for (int i = 0; i < 520; i++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 32'h0000_0101, 32'h0, 1'b0, 32'h0);
            #1;
            if (i == 504) chk("sat errcnt@252", 32'(errorCount), 32'd254);
            if (i == 506) chk("sat errcnt@253", 32'(errorCount), 32'd255);
            if (i == 518) chk("sat req", 32'(busRequest), 32'h0);
            if (i == 519) chk("sat cpuerr", 32'(cpuError), 32'h1);
        end
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("sat errcnt final", 32'(errorCount), 32'd255);

        // Asynchronous reset in the middle of a request.
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        #1;
        chk("rst pre req",   32'(busRequest), 32'h1);
        chk("rst pre stall", 32'(cpuStall),   32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst async req",    32'(busRequest), 32'h0);
        chk("rst async stall",  32'(cpuStall),   32'h0);
        chk("rst async errcnt", 32'(errorCount), 32'h0);
        chk("rst async rdata",  cpuReadData,     32'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        chk("post rst stall",  32'(cpuStall),   32'h0);
        chk("post rst errcnt", 32'(errorCount), 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b0, 32'h0);
        #1;
        chk("post rst idle stall", 32'(cpuStall),   32'h1);
        chk("post rst idle req",   32'(busRequest), 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b1, 32'h3333_3333);
        #1;
        chk("post rst req",   32'(busRequest), 32'h1);
        chk("post rst baddr", busAddress,      32'h0000_0600);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b0, 32'h0);
        #1;
        chk("post rst done stall", 32'(cpuStall), 32'h0);
        chk("post rst rdata",      cpuReadData,   32'h3333_3333);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
- Multi-cycle bridge between the CPU memory stage and an external data bus with a request/ready handshake.
- Sits directly downstream of the memory stage. It replaces the single-cycle data memory access with a handshaked transaction.
- Stalls the pipeline while a transaction is outstanding and returns read data to memory/writeback.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of cycles in REQUEST before the access is aborted; legal range 1..255.
- ERROR_DATA, 32'hDEAD_BEEF: value returned on cpuReadData for an aborted or misaligned read.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpuAddress  input  32  byte address from the memory stage (ALU output).
- cpuWriteData  input  32  store data (register rt).
- cpuShouldWriteMemory  input  1  store request.
- cpuShouldReadMemory  input  1  load request.
- cpuReadData  output  32  load result; valid in DONE.
- cpuStall  output  1  freeze the pipeline; combinational.
- cpuError  output  1  one-cycle pulse in DONE when the access failed.
- errorCount  output  8  saturating count of failed accesses.
- busRequest  output  1  transaction valid.
- busWrite  output  1  1 = write, 0 = read.
- busAddress  output  32  word address; bits [1:0] are always 0.
- busWriteData  output  32  write data.
- busReady  input  1  slave completes the transaction this cycle.
- busReadData  input  32  read data; sampled when busReady=1.

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0 immediately, regardless of clock.
  - state=IDLE, cpuReadData=0, errorCount=0, timeout counter=0.
  - busRequest falls immediately, even mid-transaction; the in-flight access is abandoned without error.
- Access condition: access = cpuShouldWriteMemory | cpuShouldReadMemory.
  - If both are high, the access is a write.
- States:
  - IDLE: cpuStall = access.
    - Access with aligned address (cpuAddress[1:0]=0): at the edge, latch busAddress, busWriteData and busWrite; set busRequest=1; clear the counter; go to REQUEST.
    - Access with misaligned address: no bus activity; go to DONE with error set.
    - No access: stay in IDLE.
  - REQUEST: cpuStall=1; busRequest, busAddress, busWrite and busWriteData are held stable.
    - busReady=1: capture busReadData into cpuReadData (read only; on a write cpuReadData is left unchanged); busRequest→0; go to DONE, no error.
    - busReady=0: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 and busReady is still 0, abort: busRequest→0, cpuReadData=ERROR_DATA for a read, go to DONE with error set.
    - busReady takes priority over timeout when both occur in the same cycle.
  - DONE: lasts exactly one cycle, then goes to IDLE.
    - cpuStall=0, so the pipeline advances on this edge.
    - cpuError=1 only if the error flag is set.
    - errorCount increments on the DONE edge when error is set, saturating at 255.
    - The access presented in DONE is the one just served and is not re-issued; the next access is evaluated in IDLE.
- Latency:
  - Access seen in cycle N; REQUEST from N+1.
  - busReady in cycle M gives DONE in M+1, so the minimum total is 3 cycles (N, N+1, N+2).
  - Timeout: busRequest stays high for exactly TIMEOUT_CYCLES cycles.
- cpuReadData holds its value between accesses; it is updated only on a completed or aborted read.
- busReady outside REQUEST is ignored.

Test Plan:
- Aligned read:
  - Stimulus: cpuShouldReadMemory=1, cpuAddress=0x100; slave asserts busReady 2 cycles after busRequest with busReadData=0x12345678.
  - Required: busRequest high for 3 cycles with busAddress=0x100 and busWrite=0; cpuStall high from the first cycle until DONE; cpuReadData=0x12345678 in DONE; cpuError=0.
- Aligned write:
  - Stimulus: store to 0x204 with data 0xA5A5A5A5; busReady in the first REQUEST cycle.
  - Required: busWrite=1 and busWriteData=0xA5A5A5A5; total stall is 2 cycles; cpuReadData unchanged.
- Misaligned load:
  - Stimulus: load from 0x102.
  - Required: no busRequest; DONE on the next cycle with cpuError=1 and cpuReadData=0xDEADBEEF; errorCount 0→1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; read with busReady held at 0.
  - Required: busRequest high for exactly 4 cycles; DONE with cpuError=1 and ERROR_DATA; in a second run, busReady asserted on the 4th cycle completes normally instead.
- Simultaneous read/write:
  - Stimulus: cpuShouldReadMemory and cpuShouldWriteMemory both high; then 260 misaligned accesses in sequence.
  - Required: the combined access is issued as busWrite=1; errorCount saturates at 255.
- Reset mid-REQUEST:
  - Stimulus: pull reset low between clock edges while busRequest is high.
  - Required: busRequest and cpuStall drop immediately without waiting for a clock edge; after reset is released, state is IDLE and errorCount=0.
